// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
//   Multi-cycle control FSM for an RV32I-subset datapath. It sequences
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives every datapath strobe.
//   One memory port is shared by instruction fetch and data access. The block
//   counts retired instructions. It enters a sticky TRAP state on an illegal
//   encoding or when a memory request times out.
//
//   Memory handshake: while mem_req=1 the request is held unchanged. The memory
//   completes it in the cycle where mem_ready=1. mem_ready is ignored whenever
//   mem_req=0. If the request is still pending after MEM_TIMEOUT cycles the
//   FSM traps.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   instr[31:0]           instruction register contents (stable DECODE..end)
//   alu_zero              ALU result == 0 (used by branches in EXEC)
//   mem_ready             memory completes the current request this cycle
//   mem_req/mem_sel/mem_we  memory request, address select (0 PC, 1 ALU), store
//   ir_write              load IR from memory read data
//   pc_write/pc_src       PC update enable; 0 = PC+4, 1 = branch target
//   reg_write/wb_sel      write rd; 0 = ALU result, 1 = memory read data
//   alu_src_b/alu_op[3:0] ALU operand B select (1 = imm) and operation
//   trap                  sticky error flag (registered)
//   state[2:0]            FSM state (registered): 0 FETCH 1 DECODE 2 EXEC 3 MEM 4 WB 7 TRAP
//   retired[CNT_W-1:0]    retired-instruction count (registered, wraps)
module riscv_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             wb_sel,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // The wait counter holds (wait cycle number - 1), so it spans 0..MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               wait_inc;
  logic               retire_inc;
  logic               trap_q;
  logic [CNT_W-1:0]   retired_q;

  // ---------------- decode ----------------
  logic [6:0] opcode;
  logic [2:0] fn3;
  logic       f7b;
  logic       is_r, is_i, is_load, is_store, is_beq, is_bne, is_branch, legal;
  logic       rd_nonzero;
  logic [3:0] alu_func;
  logic       unused_instr_bits;

  assign opcode     = instr[6:0];
  assign fn3        = instr[14:12];
  assign f7b        = instr[30];
  assign rd_nonzero = (instr[11:7] != 5'd0);

  assign is_r      = (opcode == 7'b0110011);
  assign is_i      = (opcode == 7'b0010011);
  assign is_load   = (opcode == 7'b0000011) && (fn3 == 3'b010);
  assign is_store  = (opcode == 7'b0100011) && (fn3 == 3'b010);
  assign is_beq    = (opcode == 7'b1100011) && (fn3 == 3'b000);
  assign is_bne    = (opcode == 7'b1100011) && (fn3 == 3'b001);
  assign is_branch = is_beq | is_bne;
  assign legal     = is_r | is_i | is_load | is_store | is_branch;

  // Register operands and immediate bits are consumed by the datapath only.
  assign unused_instr_bits = ^{instr[31], instr[29:15]};

  // ALU function for R/I-type. Only R-type uses f7b to pick SUB; I-type 000
  // is always ADD because bit 30 is part of its immediate there.
  always_comb begin
    alu_func = ALU_ADD;
    case (fn3)
      3'b000: alu_func = (is_r && f7b) ? ALU_SUB : ALU_ADD;
      3'b001: alu_func = ALU_SLL;
      3'b010: alu_func = ALU_SLT;
      3'b011: alu_func = ALU_SLTU;
      3'b100: alu_func = ALU_XOR;
      3'b101: alu_func = f7b ? ALU_SRA : ALU_SRL;
      3'b110: alu_func = ALU_OR;
      default: alu_func = ALU_AND;
    endcase
  end

  // ---------------- next state / strobes ----------------
  always_comb begin
    state_d    = state_q;
    wait_inc   = 1'b0;
    retire_inc = 1'b0;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;

    // Reset suppresses every strobe, including a completion in the same cycle.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_d  = S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            state_d = S_TRAP;
          end else begin
            wait_inc = 1'b1;
          end
        end

        S_DECODE: begin
          state_d = legal ? S_EXEC : S_TRAP;
        end

        S_EXEC: begin
          if (is_branch) begin
            alu_op     = ALU_SUB;
            pc_write   = 1'b1;
            pc_src     = (is_beq & alu_zero) | (is_bne & ~alu_zero);
            retire_inc = 1'b1;
            state_d    = S_FETCH;
          end else if (is_load || is_store) begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end else begin
            alu_op    = alu_func;
            alu_src_b = is_i;
            state_d   = S_WB;
          end
        end

        S_MEM: begin
          mem_req   = 1'b1;
          mem_sel   = 1'b1;
          mem_we    = is_store;
          alu_op    = ALU_ADD;
          alu_src_b = 1'b1;
          if (mem_ready) begin
            if (is_store) begin
              pc_write   = 1'b1;
              retire_inc = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state_d = S_TRAP;
          end else begin
            wait_inc = 1'b1;
          end
        end

        S_WB: begin
          reg_write  = rd_nonzero;
          wb_sel     = is_load;
          alu_op     = (is_r || is_i) ? alu_func : ALU_ADD;
          alu_src_b  = is_i;
          pc_write   = 1'b1;
          retire_inc = 1'b1;
          state_d    = S_FETCH;
        end

        S_TRAP: state_d = S_TRAP;

        default: state_d = S_FETCH;
      endcase
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_cnt  <= '0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      // Any cycle that does not stay waiting clears the counter, so every
      // entry into FETCH or MEM starts counting from zero.
      if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
      else          wait_cnt <= '0;
      if (state_d == S_TRAP) trap_q <= 1'b1;
      if (retire_inc) retired_q <= retired_q + 1'b1;
    end
  end

  assign state   = state_q;
  assign trap    = trap_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
module tb_riscv_multicycle_ctrl;

  localparam int C_R = 0, C_I = 1, C_L = 2, C_S = 3, C_B = 4, C_X = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_sel, mem_we, ir_write, pc_write, pc_src;
  logic        reg_write, wb_sel, alu_src_b, trap;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] retired;

  riscv_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_sel(mem_sel),
    .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .trap(trap), .state(state),
    .retired(retired)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [16:0] obs;
  assign obs = {state, trap, mem_req, mem_sel, mem_we, ir_write, pc_write,
                pc_src, reg_write, wb_sel, alu_src_b, alu_op};

  logic [16:0] exp_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_retired = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Fields: state trap mem_req mem_sel mem_we ir_write pc_write pc_src reg_write wb_sel alu_src_b alu_op
  function automatic logic [16:0] mk(input logic [2:0] st, input logic tr,
      input logic req, input logic sel, input logic we, input logic irw,
      input logic pcw, input logic pcs, input logic rw, input logic wbs,
      input logic srcb, input logic [3:0] op);
    return {st, tr, req, sel, we, irw, pcw, pcs, rw, wbs, srcb, op};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Outputs are sampled on the falling edge, in the middle of each cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [16:0] ev;
      string       t;
      ev = exp_q.pop_front();
      t  = tag_q.pop_front();
      check(t, {15'b0, obs}, {15'b0, ev});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic rdy, input logic zero, input logic [16:0] ev, input string tag);
    mem_ready = rdy;
    alu_zero  = zero;
    exp_q.push_back(ev);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // mem_ready=1 while in reset must not produce any strobe.
    cyc(1'b1, 1'b1, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "reset_strobes");
    reset = 1'b0;
    exp_retired = 0;
    check("reset_retired", {16'b0, retired}, 32'd0);
    check("reset_trap", {31'b0, trap}, 32'd0);
  endtask

  // Drives one instruction through its full cycle sequence. cls and op are
  // the bench's own classification of the encoding.
  task automatic run_instr(input logic [31:0] ins, input int cls, input logic [3:0] op,
      input int fw, input int dw, input logic zero, input logic pcs, input logic abort_in_mem);
    logic srcb, is_s, is_l, rw;
    is_s = (cls == C_S);
    is_l = (cls == C_L);
    srcb = (cls == C_I) || is_l || is_s;
    rw   = (ins[11:7] != 5'd0);
    instr = ins;
    for (int i = 0; i < fw; i++)
      cyc(1'b0, rnd(), mk(3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "fetch_wait");
    cyc(1'b1, rnd(), mk(3'd0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 4'd0), "fetch_ready");
    cyc(rnd(), rnd(), mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "decode");
    if (cls == C_X) begin
      for (int i = 0; i < 3; i++)
        cyc(rnd(), rnd(), mk(3'd7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "trap_hold");
      check("trap_retired_frozen", {16'b0, retired}, 32'(exp_retired));
      return;
    end
    if (cls == C_B) begin
      cyc(rnd(), zero, mk(3'd2, 0, 0, 0, 0, 0, 1, pcs, 0, 0, 0, op), "exec_branch");
      exp_retired++;
    end else begin
      cyc(rnd(), rnd(), mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, srcb, op), "exec");
    end
    if (is_l || is_s) begin
      for (int i = 0; i < dw; i++)
        cyc(1'b0, rnd(), mk(3'd3, 0, 1, 1, is_s, 0, 0, 0, 0, 0, 1, 4'd0), "mem_wait");
      if (abort_in_mem) begin
        reset = 1'b1;
        cyc(1'b1, rnd(), mk(3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "mem_reset");
        reset = 1'b0;
        exp_retired = 0;
        check("abort_state", {29'b0, state}, 32'd0);
        check("abort_retired", {16'b0, retired}, 32'd0);
        check("abort_trap", {31'b0, trap}, 32'd0);
        return;
      end
      cyc(1'b1, rnd(), mk(3'd3, 0, 1, 1, is_s, 0, is_s, 0, 0, 0, 1, 4'd0), "mem_ready");
      if (is_s) exp_retired++;
    end
    if (cls == C_R || cls == C_I || is_l) begin
      cyc(rnd(), rnd(), mk(3'd4, 0, 0, 0, 0, 0, 1, 0, rw, is_l, (cls == C_I),
          (is_l ? 4'd0 : op)), "wb");
      exp_retired++;
    end
    check("retired", {16'b0, retired}, 32'(exp_retired));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // R-type ALU ops
    run_instr(32'h002081B3, C_R, 4'd0, 1, 0, 0, 0, 0);  // ADD, ready on 2nd fetch cycle
    run_instr(32'h402081B3, C_R, 4'd1, 0, 0, 0, 0, 0);  // SUB
    run_instr(32'h0020F1B3, C_R, 4'd2, 0, 0, 0, 0, 0);  // AND
    run_instr(32'h0020E1B3, C_R, 4'd3, 2, 0, 0, 0, 0);  // OR
    run_instr(32'h0020C1B3, C_R, 4'd4, 0, 0, 0, 0, 0);  // XOR
    run_instr(32'h002091B3, C_R, 4'd5, 0, 0, 0, 0, 0);  // SLL
    run_instr(32'h0020D1B3, C_R, 4'd6, 0, 0, 0, 0, 0);  // SRL
    run_instr(32'h4020D1B3, C_R, 4'd7, 0, 0, 0, 0, 0);  // SRA
    run_instr(32'h0020A1B3, C_R, 4'd8, 0, 0, 0, 0, 0);  // SLT
    run_instr(32'h0020B1B3, C_R, 4'd9, 0, 0, 0, 0, 0);  // SLTU

    // I-type: SRAI, ADDI x0 (no reg write), ADDI with imm bit 10 set stays ADD
    run_instr(32'h4020D193, C_I, 4'd7, 0, 0, 0, 0, 0);
    run_instr(32'h00000013, C_I, 4'd0, 0, 0, 0, 0, 0);
    run_instr(32'h40008093, C_I, 4'd0, 0, 0, 0, 0, 0);

    // Branches
    run_instr(32'h00208063, C_B, 4'd1, 0, 0, 1, 1, 0);  // BEQ taken
    run_instr(32'h00209063, C_B, 4'd1, 0, 0, 1, 0, 0);  // BNE zero -> not taken
    run_instr(32'h00209063, C_B, 4'd1, 1, 0, 0, 1, 0);  // BNE taken
    run_instr(32'h00208063, C_B, 4'd1, 0, 0, 0, 0, 0);  // BEQ not taken

    // Loads and stores
    run_instr(32'h0000A183, C_L, 4'd0, 0, 2, 0, 0, 0);  // LW, 3 MEM cycles
    run_instr(32'h0000A003, C_L, 4'd0, 0, 0, 0, 0, 0);  // LW rd=x0
    run_instr(32'h0020A023, C_S, 4'd0, 1, 1, 0, 0, 0);  // SW
    run_instr(32'h0000A183, C_L, 4'd0, 0, 14, 0, 0, 0); // data ready on cycle 15

    // BLT is illegal
    run_instr(32'h0020C063, C_X, 4'd0, 0, 0, 0, 0, 0);
    do_reset();

    // LH is illegal
    run_instr(32'h00009183, C_X, 4'd0, 0, 0, 0, 0, 0);
    do_reset();

    // Fetch timeout: ready never comes in 15 cycles
    instr = 32'h002081B3;
    for (int i = 0; i < 15; i++)
      cyc(1'b0, rnd(), mk(3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "timeout_wait");
    cyc(1'b1, rnd(), mk(3'd7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "timeout_trap");
    cyc(1'b1, rnd(), mk(3'd7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0), "timeout_trap_hold");
    check("timeout_trap_flag", {31'b0, trap}, 32'd1);
    do_reset();

    // Ready on cycle 15 accepted, then opcode 0 traps
    run_instr(32'h002081B3, C_R, 4'd0, 14, 0, 0, 0, 0);
    run_instr(32'h00000000, C_X, 4'd0, 0, 0, 0, 0, 0);
    do_reset();

    // Reset during MEM of a SW, then fetch resumes
    run_instr(32'h002081B3, C_R, 4'd0, 0, 0, 0, 0, 0);
    run_instr(32'h0020A023, C_S, 4'd0, 0, 1, 0, 0, 1);
    run_instr(32'h0020A023, C_S, 4'd0, 0, 0, 0, 0, 0);
    run_instr(32'h4020D193, C_I, 4'd7, 0, 0, 0, 0, 0);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
